uart_tx_buffered: RTL and testbench

Buffered 8N1 UART transmitter that drives the board's uart_tx pin. Sits between the command/response logic (banner, ":?" dump, cipher output) and the pin. Accepts bytes through a one-cycle write strobe into a small synchronous FIFO, so the producer can push a whole response burst without waiting on each bit period. Serializes the buffered bytes LSB-first, back-to-back.

---
 rtl/uart_tx_buffered_pkg.sv | 25 ++
 rtl/uart_tx_buffered_if.sv | 22 ++
 rtl/uart_tx_buffered_fifo.sv | 48 ++++
 rtl/uart_tx_buffered.sv | 124 ++++++++++++
 tb/tb_uart_tx_buffered.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: default timing/depth, tx FSM state type,
// line levels and a constant clog2 helper.
package enigma_uart_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 104;
  localparam int unsigned DEF_FIFO_DEPTH   = 16;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Producer-side bus of the buffered UART transmitter.
interface uart_tx_buffered_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [7:0]      wr_data;
  logic            wr_en;
  logic            full;
  logic [ADDR_W:0] fifo_count;
  logic            busy;
  logic            overflow;
  logic            tx;

  modport master (
    output wr_data, wr_en,
    input  full, fifo_count, busy, overflow, tx
  );

  modport slave (
    input  wr_data, wr_en,
    output full, fifo_count, busy, overflow, tx
  );
endinterface

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit
// so full/empty fall out of the pointer difference.
module sync_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  output logic [WIDTH-1:0]  o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic             w_wr_ok;
  logic             w_rd_ok;

  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (o_count == (ADDR_W+1)'(DEPTH));
  assign o_empty   = (o_count == '0);
  assign o_rd_data = r_mem[r_rd_ptr[ADDR_W-1:0]];

  // A write while full is dropped even if a pop frees a slot the same cycle.
  assign w_wr_ok = i_wr_en && !o_full;
  assign w_rd_ok = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serializer.
// Optional macro UART_TX_OVF_FLAG_EN enables the sticky overflow flag.
module uart_tx_buffered
  import enigma_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned ADDR_W       = 4
) (
  input logic               clk,
  input logic               rst,
  uart_tx_buffered_if.slave bus
);

  localparam int unsigned CNT_W = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);

  tx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_tx;

  logic [7:0]       w_rd_data;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_bit_end;
  logic [ADDR_W:0]  w_count;

  sync_fifo #(
    .WIDTH  (8),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (bus.wr_en),
    .i_wr_data (bus.wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign w_pop     = (r_state == IDLE) && !w_empty;
  assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // tx is registered one step ahead of each state so the pin never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= IDLE_LVL;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= IDLE_LVL;
          if (!w_empty) begin
            r_shift <= w_rd_data;
            r_cnt   <= '0;
            r_tx    <= START_LVL;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= IDLE_LVL;
              r_state <= STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.tx         = r_tx;
  assign bus.full       = w_full;
  assign bus.fifo_count = w_count;
  assign bus.busy       = (r_state != IDLE) || !w_empty;

`ifdef UART_TX_OVF_FLAG_EN
  logic r_overflow;

  always_ff @(posedge clk) begin
    if (rst) r_overflow <= 1'b0;
    else if (bus.wr_en && w_full) r_overflow <= 1'b1;
  end

  assign bus.overflow = r_overflow;
`else
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: scoreboard of written bytes against a bench UART receiver,
// run on a full-size instance and a small (4 clk/bit, depth 4) instance.
module tb_uart_tx_buffered;

`ifdef UART_TX_OVF_FLAG_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  int         sel = 0;
  int         cpb = 104;
  int         depth = 16;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         frame_err = 0;

  logic [7:0] expq[$];
  logic [7:0] rxq[$];
  int         starts[$];

  uart_tx_buffered_if #(.ADDR_W(4)) bus_b ();
  uart_tx_buffered_if #(.ADDR_W(2)) bus_s ();

  uart_tx_buffered #(.CLKS_PER_BIT(104), .FIFO_DEPTH(16), .ADDR_W(4)) u_dut (
    .clk (clk), .rst (rst), .bus (bus_b)
  );
  uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .ADDR_W(2)) u_small (
    .clk (clk), .rst (rst), .bus (bus_s)
  );

  assign bus_b.wr_en   = wr_en && (sel == 0);
  assign bus_b.wr_data = wr_data;
  assign bus_s.wr_en   = wr_en && (sel == 1);
  assign bus_s.wr_data = wr_data;

  logic       tx_m, busy_m, full_m, ovf_m;
  logic [4:0] cnt_m;
  always_comb begin
    tx_m = bus_b.tx; busy_m = bus_b.busy; full_m = bus_b.full;
    ovf_m = bus_b.overflow; cnt_m = bus_b.fifo_count;
    if (sel == 1) begin
      tx_m = bus_s.tx; busy_m = bus_s.busy; full_m = bus_s.full;
      ovf_m = bus_s.overflow; cnt_m = {3'b000, bus_s.fifo_count};
    end
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Bench receiver: mid-bit sampling of the selected tx line.
  initial begin : rx_mon
    logic [7:0] b;
    logic       prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !tx_m) begin
        starts.push_back(cyc);
        repeat (cpb / 2) @(negedge clk);
        if (tx_m !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (cpb) @(negedge clk);
          b[i] = tx_m;
        end
        repeat (cpb) @(negedge clk);
        if (tx_m !== 1'b1) frame_err++;
        rxq.push_back(b);
      end
      prev = tx_m;
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expq.delete(); rxq.delete(); starts.delete();
    frame_err = 0;
  endtask

  task automatic drain(input string tag, input bit chk_gap);
    int n;
    logic [7:0] e, got;
    n = 0;
    while (busy_m && n < 20 * 16 * cpb) begin @(negedge clk); n++; end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL %s_busy_end got %b exp 0", tag, busy_m); end
    repeat (2 * cpb) @(negedge clk);
    checks++; if (rxq.size() != expq.size()) begin errors++; $display("FAIL %s_rx_count got %0d exp %0d", tag, rxq.size(), expq.size()); end
    checks++; if (frame_err != 0) begin errors++; $display("FAIL %s_framing got %0d exp 0", tag, frame_err); end
    while (expq.size() > 0) begin
      e = expq.pop_front();
      got = 'x;
      if (rxq.size() > 0) got = rxq.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL %s_rx_byte got %h exp %h", tag, got, e); end
    end
    if (chk_gap) begin
      for (int i = 1; i < starts.size(); i++) begin
        checks++;
        if (starts[i] - starts[i-1] != 10 * cpb + 1) begin
          errors++; $display("FAIL %s_frame_spacing got %0d exp %0d", tag, starts[i] - starts[i-1], 10 * cpb + 1);
        end
      end
    end
    rxq.delete(); starts.delete(); frame_err = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx_m !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx_m); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_m); end
    checks++; if (full_m !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full_m); end
    checks++; if (cnt_m !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt_m); end
    checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", ovf_m); end
  endtask

  task automatic test_single();
    int cn, s0;
    do_reset();
    expq.push_back(8'h3A);
    wr_en = 1'b1; wr_data = 8'h3A;
    @(negedge clk);
    wr_en = 1'b0;
    cn = cyc;
    checks++; if (tx_m !== 1'b1) begin errors++; $display("FAIL single_tx_write_edge got %b exp 1", tx_m); end
    checks++; if (cnt_m !== 5'd1) begin errors++; $display("FAIL single_count_write got %0d exp 1", cnt_m); end
    checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy_m); end
    wait_until(cn + 1);
    checks++; if (tx_m !== 1'b0) begin errors++; $display("FAIL single_start_fall got %b exp 0", tx_m); end
    checks++; if (cnt_m !== 5'd0) begin errors++; $display("FAIL single_count_pop got %0d exp 0", cnt_m); end
    wait_until(cn + cpb);
    checks++; if (tx_m !== 1'b0) begin errors++; $display("FAIL single_start_end got %b exp 0", tx_m); end
    wait_until(cn + 2 * cpb + 1);
    checks++; if (tx_m !== 1'b1) begin errors++; $display("FAIL single_bit1 got %b exp 1", tx_m); end
    wait_until(cn + 10 * cpb);
    checks++; if (busy_m !== 1'b1 || tx_m !== 1'b1) begin errors++; $display("FAIL single_stop_last got busy=%b tx=%b exp busy=1 tx=1", busy_m, tx_m); end
    wait_until(cn + 10 * cpb + 1);
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %b exp 0", busy_m); end
    s0 = (starts.size() > 0) ? starts[0] : -1;
    checks++; if (s0 != cn + 1) begin errors++; $display("FAIL single_start_cycle got %0d exp %0d", s0, cn + 1); end
    drain("single", 1'b0);
  endtask

  task automatic test_burst();
    string banner;
    banner = "ENIGMA UART v1\r\n";
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = banner[i];
      expq.push_back(banner[i]);
      @(negedge clk);
    end
    wr_en = 1'b0;
    checks++; if (cnt_m !== 5'd15) begin errors++; $display("FAIL burst_count got %0d exp 15", cnt_m); end
    drain("burst", 1'b1);
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < depth + 2; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      if (i <= depth) expq.push_back(8'(i));
      @(negedge clk);
      if (i == depth - 1) begin
        checks++; if (full_m !== 1'b0) begin errors++; $display("FAIL full_early got %b exp 0", full_m); end
      end
      if (i == depth) begin
        checks++; if (full_m !== 1'b1) begin errors++; $display("FAIL full_assert got %b exp 1", full_m); end
        checks++; if (cnt_m !== 5'(depth)) begin errors++; $display("FAIL full_count got %0d exp %0d", cnt_m, depth); end
      end
    end
    wr_en = 1'b0;
    checks++; if (cnt_m !== 5'(depth)) begin errors++; $display("FAIL full_drop_count got %0d exp %0d", cnt_m, depth); end
    checks++; if (ovf_m !== OVF_EN) begin errors++; $display("FAIL full_overflow got %b exp %b", ovf_m, OVF_EN); end
    drain("full", 1'b1);
    checks++; if (ovf_m !== OVF_EN) begin errors++; $display("FAIL full_overflow_sticky got %b exp %b", ovf_m, OVF_EN); end
  endtask

  task automatic test_drain_write();
    int n, cp;
    do_reset();
    for (int i = 0; i <= depth; i++) begin
      wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
      expq.push_back(8'h40 + 8'(i));
      @(negedge clk);
    end
    wr_en = 1'b0;
    n = 0;
    while (full_m && n < 20 * cpb) begin @(negedge clk); n++; end
    cp = cyc;
    checks++; if (full_m !== 1'b0 || cnt_m !== 5'(depth - 1)) begin errors++; $display("FAIL drain_first_pop got full=%b cnt=%0d exp full=0 cnt=%0d", full_m, cnt_m, depth - 1); end
    wait_until(cp + 10 * cpb);
    checks++; if (tx_m !== 1'b1) begin errors++; $display("FAIL drain_idle_gap got %b exp 1", tx_m); end
    wr_en = 1'b1; wr_data = 8'hA5;
    expq.push_back(8'hA5);
    @(negedge clk);
    wr_en = 1'b0;
    checks++; if (cnt_m !== 5'(depth - 1)) begin errors++; $display("FAIL drain_write_pop_count got %0d exp %0d", cnt_m, depth - 1); end
    checks++; if (tx_m !== 1'b0) begin errors++; $display("FAIL drain_pop_start got %b exp 0", tx_m); end
    drain("drain", 1'b1);
  endtask

  task automatic test_reset_midframe();
    int cn;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      @(negedge clk);
      if (i == 0) cn = cyc;
    end
    wr_en = 1'b0;
    checks++; if (cnt_m !== 5'd5) begin errors++; $display("FAIL midrst_queued got %0d exp 5", cnt_m); end
    wait_until(cn + 4 * cpb + cpb / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (tx_m !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b exp 1", tx_m); end
    checks++; if (cnt_m !== 5'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", cnt_m); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy_m); end
    checks++; if (ovf_m !== 1'b0) begin errors++; $display("FAIL midrst_overflow got %b exp 0", ovf_m); end
    repeat (12 * cpb) @(negedge clk);
    rxq.delete(); starts.delete(); frame_err = 0;
    repeat (12 * cpb) @(negedge clk);
    checks++; if (starts.size() != 0) begin errors++; $display("FAIL midrst_no_frames got %0d exp 0", starts.size()); end
    checks++; if (tx_m !== 1'b1 || busy_m !== 1'b0) begin errors++; $display("FAIL midrst_quiet got tx=%b busy=%b exp tx=1 busy=0", tx_m, busy_m); end
  endtask

  initial begin
    sel = 0; cpb = 104; depth = 16;
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_drain_write();
    test_reset_midframe();
    sel = 1; cpb = 4; depth = 4;
    test_reset();
    test_single();
    test_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
